demux_vc: RTL and testbench

DEMUX_VC -- requirements
Module: demux_vc

---
 rtl/demux_vc_if.sv | 30 +++
 rtl/demux_vc.sv | 94 +++++++++
 tb/tb_demux_vc.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_vc_if.sv
// Handshake and data bundle between the upstream word source and the two VC FIFOs.
// master drives words and pause levels; slave is the demultiplexer.
interface demux_vc_if #(
  parameter int DATA_SIZE = 6
);
  logic                 valid_in;
  logic [DATA_SIZE-1:0] data_in;
  logic                 pause_VC0;
  logic                 pause_VC1;
  logic                 ready_out;
  logic                 push_VC0;
  logic                 push_VC1;
  logic [DATA_SIZE-1:0] data_VC0;
  logic [DATA_SIZE-1:0] data_VC1;
  logic [7:0]           count_VC0;
  logic [7:0]           count_VC1;
  logic                 drop;

  modport master (
    output valid_in, data_in, pause_VC0, pause_VC1,
    input  ready_out, push_VC0, push_VC1, data_VC0, data_VC1,
           count_VC0, count_VC1, drop
  );

  modport slave (
    input  valid_in, data_in, pause_VC0, pause_VC1,
    output ready_out, push_VC0, push_VC1, data_VC0, data_VC1,
           count_VC0, count_VC1, drop
  );
endinterface

// File: rtl/demux_vc.sv
// Routes incoming words to one of two virtual-channel FIFOs by a destination bit,
// parking a single word in a hold register while its target FIFO is paused.
module demux_vc #(
  parameter int DATA_SIZE = 6,
  parameter int DEST_BIT  = DATA_SIZE - 2
) (
  input logic         clk,
  input logic         reset_L,
  demux_vc_if.slave   bus
);

  typedef enum logic {PASS, HOLD} state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] hold_data;
  logic                 hold_dest;

  logic                 in_dest;
  logic                 in_paused;
  logic                 held_paused;
  logic                 push_now;
  logic                 push_dest;
  logic [DATA_SIZE-1:0] push_word;

  assign in_dest     = bus.data_in[DEST_BIT];
  assign in_paused   = in_dest   ? bus.pause_VC1 : bus.pause_VC0;
  assign held_paused = hold_dest ? bus.pause_VC1 : bus.pause_VC0;

  // In PASS the live word goes straight through; in HOLD only the parked word can leave.
  always_comb begin
    push_now  = 1'b0;
    push_dest = in_dest;
    push_word = bus.data_in;
    if (state == PASS) begin
      push_now = bus.valid_in && !in_paused;
    end else begin
      push_now  = !held_paused;
      push_dest = hold_dest;
      push_word = hold_data;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state         <= PASS;
      hold_data     <= '0;
      hold_dest     <= 1'b0;
      bus.ready_out <= 1'b1;
      bus.push_VC0  <= 1'b0;
      bus.push_VC1  <= 1'b0;
      bus.data_VC0  <= '0;
      bus.data_VC1  <= '0;
      bus.count_VC0 <= 8'd0;
      bus.count_VC1 <= 8'd0;
      bus.drop      <= 1'b0;
    end else begin
      bus.push_VC0 <= 1'b0;
      bus.push_VC1 <= 1'b0;

      if (push_now) begin
        if (push_dest) begin
          bus.push_VC1  <= 1'b1;
          bus.data_VC1  <= push_word;
          bus.count_VC1 <= bus.count_VC1 + 8'd1;
        end else begin
          bus.push_VC0  <= 1'b1;
          bus.data_VC0  <= push_word;
          bus.count_VC0 <= bus.count_VC0 + 8'd1;
        end
      end

      if (state == PASS) begin
        if (bus.valid_in && in_paused) begin
          hold_data     <= bus.data_in;
          hold_dest     <= in_dest;
          state         <= HOLD;
          bus.ready_out <= 1'b0;
        end
      end else begin
        // A word offered while not ready is lost, including on the release edge.
        if (bus.valid_in) begin
          bus.drop <= 1'b1;
        end
        if (!held_paused) begin
          hold_data     <= '0;
          hold_dest     <= 1'b0;
          state         <= PASS;
          bus.ready_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_vc.sv
// Directed bench for demux_vc: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at the interesting points of each scenario.
module tb_demux_vc;

  localparam int DATA_SIZE = 6;
  localparam int DEST_BIT  = 4;

  logic clk     = 1'b0;
  logic reset_L = 1'b0;

  always #5 clk = ~clk;

  demux_vc_if #(.DATA_SIZE(DATA_SIZE)) bus ();

  demux_vc #(.DATA_SIZE(DATA_SIZE), .DEST_BIT(DEST_BIT)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DATA_SIZE-1:0] word;
    int                   vc;
  } held_t;

  held_t                pending[$];
  logic [DATA_SIZE-1:0] m_data[2];
  int                   m_count[2];
  bit                   m_push[2];
  bit                   m_drop;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit pauseOf(input int vc);
    return (vc == 1) ? bus.pause_VC1 : bus.pause_VC0;
  endfunction

  task automatic deliver(input int vc, input logic [DATA_SIZE-1:0] w);
    m_push[vc]  = 1'b1;
    m_data[vc]  = w;
    m_count[vc] = (m_count[vc] + 1) % 256;
  endtask

  // Reference model: at most one parked word; ready means nothing is parked.
  initial begin
    int vc_in;
    forever begin
      @(posedge clk or negedge reset_L);
      if (!reset_L) begin
        pending.delete();
        m_data  = '{default: '0};
        m_count = '{0, 0};
        m_push  = '{0, 0};
        m_drop  = 1'b0;
      end else begin
        m_push = '{0, 0};
        if (pending.size() != 0) begin
          if (bus.valid_in) m_drop = 1'b1;
          if (!pauseOf(pending[0].vc)) begin
            deliver(pending[0].vc, pending[0].word);
            void'(pending.pop_front());
          end
        end else if (bus.valid_in) begin
          vc_in = int'(bus.data_in[DEST_BIT]);
          if (!pauseOf(vc_in)) deliver(vc_in, bus.data_in);
          else pending.push_back('{bus.data_in, vc_in});
        end
      end
    end
  end

  task automatic checkOutput();
    checkValue("push_VC0",  bus.push_VC0,  m_push[0]);
    checkValue("push_VC1",  bus.push_VC1,  m_push[1]);
    checkValue("data_VC0",  bus.data_VC0,  m_data[0]);
    checkValue("data_VC1",  bus.data_VC1,  m_data[1]);
    checkValue("count_VC0", bus.count_VC0, m_count[0]);
    checkValue("count_VC1", bus.count_VC1, m_count[1]);
    checkValue("drop",      bus.drop,      m_drop);
    checkValue("ready_out", bus.ready_out, pending.size() == 0);
    checkValue("push_excl", bus.push_VC0 & bus.push_VC1, 0);
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  // Drives one cycle of inputs and returns 1 ns after the edge that samples them.
  task automatic applyStimulus(input logic v, input logic [DATA_SIZE-1:0] d, input logic p0, input logic p1);
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.pause_VC0 = p0;
    bus.pause_VC1 = p1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, "_ready"},  bus.ready_out, 1);
    checkValue({tag, "_push0"},  bus.push_VC0,  0);
    checkValue({tag, "_push1"},  bus.push_VC1,  0);
    checkValue({tag, "_data0"},  bus.data_VC0,  0);
    checkValue({tag, "_data1"},  bus.data_VC1,  0);
    checkValue({tag, "_count0"}, bus.count_VC0, 0);
    checkValue({tag, "_count1"}, bus.count_VC1, 0);
    checkValue({tag, "_drop"},   bus.drop,      0);
  endtask

  task automatic resetDut();
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.pause_VC0 = 1'b0;
    bus.pause_VC1 = 1'b0;
    reset_L = 1'b0;
    #2;
    checkResetState("rst");
    reset_L = 1'b1;
  endtask

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.pause_VC0 = 1'b0;
    bus.pause_VC1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("por");
    reset_L = 1'b1;

    $display("[TB] single word to VC0");
    applyStimulus(1'b1, 6'b000101, 1'b0, 1'b0);
    checkValue("s1_push0",  bus.push_VC0,  1);
    checkValue("s1_push1",  bus.push_VC1,  0);
    checkValue("s1_data0",  bus.data_VC0,  6'b000101);
    checkValue("s1_count0", bus.count_VC0, 1);
    applyStimulus(1'b0, 6'b111111, 1'b0, 1'b0);
    checkValue("s1_push0_off", bus.push_VC0, 0);
    checkValue("s1_data0_hold", bus.data_VC0, 6'b000101);

    $display("[TB] back-to-back words");
    resetDut();
    applyStimulus(1'b1, 6'b010011, 1'b0, 1'b0);
    checkValue("s2_w1_push1", bus.push_VC1, 1);
    checkValue("s2_w1_data1", bus.data_VC1, 6'b010011);
    applyStimulus(1'b1, 6'b000111, 1'b0, 1'b0);
    checkValue("s2_w2_push0", bus.push_VC0, 1);
    checkValue("s2_w2_push1", bus.push_VC1, 0);
    checkValue("s2_w2_data0", bus.data_VC0, 6'b000111);
    applyStimulus(1'b1, 6'b010001, 1'b0, 1'b0);
    checkValue("s2_w3_push1", bus.push_VC1, 1);
    checkValue("s2_w3_data1", bus.data_VC1, 6'b010001);
    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0);
    checkValue("s2_count1", bus.count_VC1, 2);
    checkValue("s2_count0", bus.count_VC0, 1);

    $display("[TB] hold on paused VC1");
    resetDut();
    applyStimulus(1'b1, 6'b010110, 1'b0, 1'b1);
    checkValue("s3_ready_hold", bus.ready_out, 0);
    checkValue("s3_nopush1",    bus.push_VC1,  0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'b000000, logic'(i[0]), 1'b1);
      checkValue("s3_still_held", {bus.ready_out, bus.push_VC0, bus.push_VC1}, 3'b000);
    end
    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0);
    checkValue("s3_rel_push1",  bus.push_VC1,  1);
    checkValue("s3_rel_data1",  bus.data_VC1,  6'b010110);
    checkValue("s3_rel_ready",  bus.ready_out, 1);
    checkValue("s3_rel_count1", bus.count_VC1, 1);
    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0);
    checkValue("s3_push1_off",  bus.push_VC1, 0);
    checkValue("s3_data1_hold", bus.data_VC1, 6'b010110);

    $display("[TB] word offered during hold is dropped");
    resetDut();
    applyStimulus(1'b1, 6'b010000, 1'b0, 1'b1);
    checkValue("s4_drop_early", bus.drop, 0);
    applyStimulus(1'b1, 6'b000001, 1'b0, 1'b1);
    checkValue("s4_drop_set", bus.drop, 1);
    applyStimulus(1'b0, 6'b000000, 1'b1, 1'b1);
    // The word presented on the release edge is also lost.
    applyStimulus(1'b1, 6'b000011, 1'b0, 1'b0);
    checkValue("s4_rel_push1", bus.push_VC1, 1);
    checkValue("s4_rel_data1", bus.data_VC1, 6'b010000);
    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0);
    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0);
    checkValue("s4_count0", bus.count_VC0, 0);
    checkValue("s4_data0",  bus.data_VC0,  0);
    checkValue("s4_drop_sticky", bus.drop, 1);

    $display("[TB] VC0 counter wrap");
    resetDut();
    applyStimulus(1'b1, 6'b010010, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b1, 6'(i & 15), 1'b0, 1'b0);
    end
    checkValue("s5_count0_255", bus.count_VC0, 255);
    applyStimulus(1'b1, 6'b001111, 1'b0, 1'b0);
    checkValue("s5_count0_wrap", bus.count_VC0, 0);
    checkValue("s5_count1_kept", bus.count_VC1, 1);
    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0);

    $display("[TB] reset during hold");
    resetDut();
    applyStimulus(1'b1, 6'b000010, 1'b1, 1'b0);
    applyStimulus(1'b1, 6'b000001, 1'b1, 1'b0);
    checkValue("s6_drop_pre", bus.drop, 1);
    checkValue("s6_ready_pre", bus.ready_out, 0);
    bus.valid_in  = 1'b0;
    bus.pause_VC0 = 1'b0;
    reset_L = 1'b0;
    #2;
    checkResetState("s6_mid");
    reset_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0);
      checkValue("s6_no_push0", bus.push_VC0, 0);
    end
    checkValue("s6_count0", bus.count_VC0, 0);

    $display("[TB] mixed traffic");
    resetDut();
    for (int i = 0; i < 80; i++) begin
      applyStimulus(logic'($urandom_range(0, 1)), 6'($urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0);
    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
